// File: rtl/igpu_cmp_scheduler.sv
// rtl/igpu_cmp_scheduler.sv - round-robin scheduler sharing one pixel-block compressor
// Optional feature macro: IGPU_SCHED_STATS_EN (adds stat_blocks / stat_raw counters)
module igpu_cmp_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CMP_LAT = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*1024-1:0]     req_pixels,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        cmp_start,
    output logic [1023:0]               cmp_pixels,
    input  logic [1023:0]               cmp_lines,
    input  logic [1:0]                  cmp_flag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [511:0]                out_line,
    output logic                        out_last,
    output logic [$clog2(NUM_REQ)-1:0]  out_id,
    output logic [1:0]                  out_flag,
    output logic                        busy,
    output logic                        err_flag
`ifdef IGPU_SCHED_STATS_EN
    ,
    output logic [31:0]                 stat_blocks,
    output logic [31:0]                 stat_raw
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int LAT_W = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
    localparam logic [ID_W:0]    NREQ_W   = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CMP_LAT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_EMIT   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [1023:0]    pix_q, pix_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [511:0]     beat0_q, beat0_d;
    logic [511:0]     beat1_q, beat1_d;
    logic             two_q, two_d;
    logic [1:0]       flag_q, flag_d;
    logic             beat_q, beat_d;
    logic             err_q, err_d;

    logic [ID_W:0]    scan;
    logic             gnt_any;
    logic [ID_W-1:0]  gnt_idx;
    logic [1023:0]    gnt_pix;
    logic             last_beat;

    // First valid requester found when scanning upward from rr_q, wrapping at NUM_REQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_q} + (ID_W+1)'(k);
            if (scan >= NREQ_W) begin
                scan = scan - NREQ_W;
            end
            if (!gnt_any && req_valid[scan[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = scan[ID_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_pix = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt_idx == ID_W'(r)) begin
                gnt_pix = req_pixels[r*1024 +: 1024];
            end
        end
    end

    assign last_beat = !two_q || beat_q;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        pix_d   = pix_q;
        lat_d   = lat_q;
        beat0_d = beat0_q;
        beat1_d = beat1_q;
        two_d   = two_q;
        flag_d  = flag_q;
        beat_d  = beat_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    id_d    = gnt_idx;
                    pix_d   = gnt_pix;
                    rr_d    = (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                lat_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    // Beats are resolved here so EMIT is a plain two-entry mux.
                    flag_d = (cmp_flag == 2'b11) ? 2'b00 : cmp_flag;
                    err_d  = (cmp_flag == 2'b11);
                    case (cmp_flag)
                        2'b01: begin
                            beat0_d = cmp_lines[1023:512];
                            two_d   = 1'b0;
                        end
                        2'b10: begin
                            beat0_d = cmp_lines[1023:512];
                            beat1_d = cmp_lines[511:0];
                            two_d   = 1'b1;
                        end
                        default: begin
                            beat0_d = pix_q[1023:512];
                            beat1_d = pix_q[511:0];
                            two_d   = 1'b1;
                        end
                    endcase
                    beat_d  = 1'b0;
                    state_d = S_EMIT;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            pix_q   <= '0;
            lat_q   <= '0;
            beat0_q <= '0;
            beat1_q <= '0;
            two_q   <= 1'b0;
            flag_q  <= 2'b00;
            beat_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            pix_q   <= pix_d;
            lat_q   <= lat_d;
            beat0_q <= beat0_d;
            beat1_q <= beat1_d;
            two_q   <= two_d;
            flag_q  <= flag_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    // Gated by rst_n so a held req_valid cannot show a grant while reset is asserted.
    assign req_ready  = (rst_n && state_q == S_IDLE && gnt_any) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign cmp_start  = (state_q == S_LAUNCH);
    assign cmp_pixels = pix_q;
    assign out_valid  = (state_q == S_EMIT);
    assign out_line   = out_valid ? (beat_q ? beat1_q : beat0_q) : '0;
    assign out_last   = out_valid && last_beat;
    assign out_id     = out_valid ? id_q : '0;
    assign out_flag   = out_valid ? flag_q : 2'b00;
    assign busy       = (state_q != S_IDLE);
    assign err_flag   = err_q;

`ifdef IGPU_SCHED_STATS_EN
    logic [31:0] stat_blocks_q;
    logic [31:0] stat_raw_q;
    logic        blk_done;

    assign blk_done = out_valid && out_ready && last_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_blocks_q <= '0;
            stat_raw_q    <= '0;
        end else if (blk_done) begin
            stat_blocks_q <= stat_blocks_q + 32'd1;
            if (flag_q == 2'b00) begin
                stat_raw_q <= stat_raw_q + 32'd1;
            end
        end
    end

    assign stat_blocks = stat_blocks_q;
    assign stat_raw    = stat_raw_q;
`endif

endmodule

// File: tb/tb_igpu_cmp_scheduler.sv
// tb/tb_igpu_cmp_scheduler.sv - self-checking bench for igpu_cmp_scheduler
module tb_igpu_cmp_scheduler;
    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req_valid;
    logic [N*1024-1:0]  req_pixels;
    logic [N-1:0]       req_ready;
    logic               cmp_start;
    logic [1023:0]      cmp_pixels;
    logic [1023:0]      cmp_lines;
    logic [1:0]         cmp_flag;
    logic               out_valid;
    logic               out_ready;
    logic [511:0]       out_line;
    logic               out_last;
    logic [IDW-1:0]     out_id;
    logic [1:0]         out_flag;
    logic               busy;
    logic               err_flag;
`ifdef IGPU_SCHED_STATS_EN
    logic [31:0]        stat_blocks;
    logic [31:0]        stat_raw;
`endif

    igpu_cmp_scheduler #(.NUM_REQ(N), .CMP_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_pixels(req_pixels), .req_ready(req_ready),
        .cmp_start(cmp_start), .cmp_pixels(cmp_pixels),
        .cmp_lines(cmp_lines), .cmp_flag(cmp_flag),
        .out_valid(out_valid), .out_ready(out_ready), .out_line(out_line),
        .out_last(out_last), .out_id(out_id), .out_flag(out_flag),
        .busy(busy), .err_flag(err_flag)
`ifdef IGPU_SCHED_STATS_EN
        , .stat_blocks(stat_blocks), .stat_raw(stat_raw)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model: requester pool, rr pointer, and the block in flight measured by age since accept.
    bit            pend [N];
    logic [1023:0] pix  [N];
    int            rr;
    bit            blk_active;
    int            age, bi, nb, cur_id;
    logic [1023:0] cur_pix, cur_lines, nxt_lines;
    logic [1:0]    cur_flag, nxt_flag;
    logic [511:0]  exp_beat [2];
    int unsigned   m_blocks, m_raw;
    bit            rand_mode, refill, seen_valid;
    int            stall_left, stall_obs, cyc, acc_cyc, first_lat, err_cnt;
    int            dut_grants [$];
    logic [511:0]  beat_log [$];
    bit            last_log [$];
    int            id_log [$];
    logic [1:0]    flag_log [$];

    task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [1023:0] rand1024();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic int rr_pick(logic [N-1:0] v, int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [1:0] eff(logic [1:0] f);
        return (f == 2'b11) ? 2'b00 : f;
    endfunction

    function automatic bit any_pend();
        for (int r = 0; r < N; r++) if (pend[r]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void clear_logs();
        dut_grants.delete(); beat_log.delete(); last_log.delete();
        id_log.delete(); flag_log.delete();
        err_cnt = 0; stall_obs = 0;
    endfunction

    function automatic void model_reset();
        rr = 0; blk_active = 1'b0; age = 0; bi = 0;
        m_blocks = 0; m_raw = 0;
    endfunction

    task automatic check_zero(string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_cmp_start"}, cmp_start, 0);
        chk({tag, "_cmp_pixels"}, cmp_pixels[511:0], 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_line"}, out_line, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_id"}, out_id, 0);
        chk({tag, "_out_flag"}, out_flag, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err_flag"}, err_flag, 0);
`ifdef IGPU_SCHED_STATS_EN
        chk({tag, "_stat_blocks"}, stat_blocks, 0);
        chk({tag, "_stat_raw"}, stat_raw, 0);
`endif
    endtask

    task automatic check_and_update();
        int g;
        logic [N-1:0] exp_rdy;
        bit ev;
        g = blk_active ? -1 : rr_pick(req_valid, rr);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        ev = blk_active && age >= LAT + 2;
        chk("req_ready", req_ready, exp_rdy);
        chk("cmp_start", cmp_start, blk_active && age == 1);
        chk("busy", busy, blk_active);
        chk("out_valid", out_valid, ev);
        chk("err_flag", err_flag, blk_active && age == LAT + 2 && cur_flag == 2'b11);
        if (blk_active && age <= LAT + 1) begin
            chk("cmp_pixels_hi", cmp_pixels[1023:512], cur_pix[1023:512]);
            chk("cmp_pixels_lo", cmp_pixels[511:0], cur_pix[511:0]);
        end
        if (ev) begin
            chk("out_line", out_line, exp_beat[bi]);
            chk("out_last", out_last, bi == nb - 1);
            chk("out_id", out_id, cur_id);
            chk("out_flag", out_flag, eff(cur_flag));
        end
`ifdef IGPU_SCHED_STATS_EN
        chk("stat_blocks", stat_blocks, m_blocks);
        chk("stat_raw", stat_raw, m_raw);
`endif
        if (err_flag) err_cnt++;
        if (out_valid && !out_ready) stall_obs++;
        if (out_valid && !seen_valid) begin
            seen_valid = 1'b1;
            first_lat  = cyc - acc_cyc;
        end
        if (out_valid && out_ready) begin
            beat_log.push_back(out_line); last_log.push_back(out_last);
            id_log.push_back(int'(out_id)); flag_log.push_back(out_flag);
        end
        for (int r = 0; r < N; r++) if (req_ready[r]) dut_grants.push_back(r);

        if (blk_active) begin
            if (ev && out_ready) begin
                bi++;
                if (bi == nb) begin
                    blk_active = 1'b0;
                    m_blocks++;
                    if (eff(cur_flag) == 2'b00) m_raw++;
                end
            end
            if (blk_active) age++;
        end else if (g >= 0) begin
            cur_id = g; cur_pix = pix[g]; cur_flag = nxt_flag; cur_lines = nxt_lines;
            if (cur_flag == 2'b01) begin
                nb = 1; exp_beat[0] = cur_lines[1023:512]; exp_beat[1] = '0;
            end else if (cur_flag == 2'b10) begin
                nb = 2; exp_beat[0] = cur_lines[1023:512]; exp_beat[1] = cur_lines[511:0];
            end else begin
                nb = 2; exp_beat[0] = cur_pix[1023:512]; exp_beat[1] = cur_pix[511:0];
            end
            rr = (g + 1) % N;
            blk_active = 1'b1; age = 1; bi = 0;
            seen_valid = 1'b0; acc_cyc = cyc;
            if (refill) pix[g] = rand1024();
            else pend[g] = 1'b0;
        end
        cyc++;
    endtask

    // Entered and left just after a rising edge.
    task automatic step();
        if (rand_mode) begin
            for (int r = 0; r < N; r++) begin
                if (!pend[r] && $urandom_range(0, 3) == 0) begin
                    pend[r] = 1'b1; pix[r] = rand1024();
                end else if (pend[r] && $urandom_range(0, 31) == 0) begin
                    pend[r] = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            nxt_flag  = 2'($urandom_range(0, 3));
            nxt_lines = rand1024();
        end else if (stall_left > 0 && blk_active && bi == 1 && dut_grants.size() == 2) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
        for (int r = 0; r < N; r++) begin
            req_valid[r] = pend[r];
            req_pixels[r*1024 +: 1024] = pix[r];
        end
        if (blk_active && age == LAT + 1) begin
            cmp_lines = cur_lines; cmp_flag = cur_flag;
        end else begin
            cmp_lines = rand1024(); cmp_flag = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        check_and_update();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(string name, int budget);
        int k = 0;
        while ((blk_active || any_pend()) && k < budget) begin
            step();
            k++;
        end
        if (blk_active || any_pend()) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: timeout after %0d cycles", name, budget);
        end
    endtask

    task automatic async_reset_mid();
        #2 rst_n = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        req_valid = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    localparam logic [511:0] L0 = {16{32'h1111_0001}};
    localparam logic [511:0] L1 = {16{32'h2222_0002}};
    localparam logic [511:0] PA5 = {64{8'hA5}};

    initial begin
        logic [1023:0] saved;
        int k;
        rst_n = 1'b0; req_valid = '0; req_pixels = '0; out_ready = 1'b0;
        cmp_lines = '0; cmp_flag = 2'b00;
        for (int r = 0; r < N; r++) begin pend[r] = 1'b0; pix[r] = '0; end
        rand_mode = 1'b0; refill = 1'b0; stall_left = 0; cyc = 0; acc_cyc = 0;
        first_lat = 0; seen_valid = 1'b0; nb = 1; cur_id = 0; cur_flag = 2'b00;
        cur_pix = '0; cur_lines = '0; nxt_lines = '0; nxt_flag = 2'b01;
        exp_beat[0] = '0; exp_beat[1] = '0;
        model_reset();
        clear_logs();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-line block from requester 0.
        pend[0] = 1'b1; pix[0] = rand1024();
        nxt_flag = 2'b01; nxt_lines = {L0, L1};
        wait_done("t1", 40);
        chk("t1_grant", dut_grants[0], 0);
        chk("t1_nbeats", beat_log.size(), 1);
        chk("t1_line", beat_log[0], L0);
        chk("t1_last", last_log[0], 1);
        chk("t1_id", id_log[0], 0);
        chk("t1_flag", flag_log[0], 2'b01);
        chk("t1_latency", first_lat, 5);

        // Two-line block.
        clear_logs();
        pend[0] = 1'b1; pix[0] = rand1024();
        nxt_flag = 2'b10; nxt_lines = {L0, L1};
        wait_done("t2", 40);
        chk("t2_nbeats", beat_log.size(), 2);
        chk("t2_line0", beat_log[0], L0);
        chk("t2_line1", beat_log[1], L1);
        chk("t2_last0", last_log[0], 0);
        chk("t2_last1", last_log[1], 1);

        // Incompressible block: raw pixels go out.
        clear_logs();
        pend[0] = 1'b1; pix[0] = {PA5, PA5};
        nxt_flag = 2'b00; nxt_lines = {L1, L0};
        wait_done("t3", 40);
        chk("t3_nbeats", beat_log.size(), 2);
        chk("t3_beat0", beat_log[0], PA5);
        chk("t3_beat1", beat_log[1], PA5);
        chk("t3_flag", flag_log[0], 2'b00);
`ifdef IGPU_SCHED_STATS_EN
        chk("t3_stat_raw", stat_raw, 1);
        chk("t3_stat_blocks", stat_blocks, 3);
`endif

        // Illegal flag: one error pulse, raw beats, flag reported as 00.
        clear_logs();
        pend[0] = 1'b1; pix[0] = rand1024(); saved = pix[0];
        nxt_flag = 2'b11; nxt_lines = {L0, L1};
        wait_done("t6a", 40);
        chk("t6a_err_pulses", err_cnt, 1);
        chk("t6a_beat0", beat_log[0], saved[1023:512]);
        chk("t6a_beat1", beat_log[1], saved[511:0]);
        chk("t6a_flag", flag_log[1], 2'b00);

        // All four requesters held valid; reset during WAIT of the first block.
        for (int r = 0; r < N; r++) begin pend[r] = 1'b1; pix[r] = rand1024(); end
        refill = 1'b1; nxt_flag = 2'b10; nxt_lines = {L1, L0};
        k = 0;
        while (!(blk_active && age == 2) && k < 20) begin step(); k++; end
        if (!(blk_active && age == 2)) begin
            n_cmp++; n_bad++;
            $display("FAIL t6b_reach_wait: timeout after %0d cycles", k);
        end
        async_reset_mid();

        // Five grants in round-robin order, with a 10-cycle stall inside the second block.
        clear_logs();
        stall_left = 10;
        k = 0;
        while (dut_grants.size() < 5 && k < 200) begin step(); k++; end
        refill = 1'b0;
        for (int r = 0; r < N; r++) pend[r] = 1'b0;
        wait_done("t4", 60);
        chk("t4_ngrants", dut_grants.size(), 5);
        chk("t4_g0", dut_grants[0], 0);
        chk("t4_g1", dut_grants[1], 1);
        chk("t4_g2", dut_grants[2], 2);
        chk("t4_g3", dut_grants[3], 3);
        chk("t4_g4", dut_grants[4], 0);
        chk("t4_nbeats", id_log.size(), 10);
        chk("t4_id_b2", id_log[2], 1);
        chk("t4_id_b8", id_log[8], 0);
        chk("t5_stall_cycles", stall_obs, 10);
        chk("t5_beat3", beat_log[3], L0);
`ifdef IGPU_SCHED_STATS_EN
        chk("t4_stat_blocks", stat_blocks, 5);
        chk("t4_stat_raw", stat_raw, 0);
`endif

        // Randomized traffic.
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        for (int r = 0; r < N; r++) pend[r] = 1'b0;
        wait_done("drain", 60);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
